// File: rtl/machine_ctl_if.sv
// Control bus between the CPU sequencer (machine_ctl) and the datapath.
// The master modport is the sequencer: it samples the fetch strobe,
// opcode and zero flag, and drives the control strobes.
// The slave modport is the datapath/clock-generator side.
interface machine_ctl_if;
    logic       fetch;
    logic [2:0] opcode;
    logic       zero;
    logic       inc_pc;
    logic       load_acc;
    logic       load_pc;
    logic       rd;
    logic       wr;
    logic       load_ir;
    logic       datactl_ena;
    logic       halt;

    modport master (
        input  fetch, opcode, zero,
        output inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena, halt
    );

    modport slave (
        output fetch, opcode, zero,
        input  inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena, halt
    );
endinterface

// File: rtl/machine_ctl.sv
// machine_ctl: eight-step instruction sequencer for a simple accumulator CPU.
// After the first sampled fetch strobe it walks S0..S7, one step per clock,
// and registers each step's control word onto the outputs.
// Optional feature: define MACHINE_CTL_HALT_LATCH_EN to make HLT enter a
// sticky HALTED state (halt=1, everything else 0) until reset. Without it,
// HLT only pulses halt for one cycle and sequencing carries on.
module machine_ctl (
    input  logic          clk,
    input  logic          reset,
    machine_ctl_if.master bus
);

    localparam logic [2:0] OP_HLT  = 3'b000;
    localparam logic [2:0] OP_SKZ  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_ANDD = 3'b011;
    localparam logic [2:0] OP_XORR = 3'b100;
    localparam logic [2:0] OP_LDA  = 3'b101;
    localparam logic [2:0] OP_STO  = 3'b110;
    localparam logic [2:0] OP_JMP  = 3'b111;

    // S_HALTED is only entered when the halt latch is built in; in the
    // default build it is one of the unreachable encodings.
    typedef enum logic [3:0] {
        S0       = 4'd0,
        S1       = 4'd1,
        S2       = 4'd2,
        S3       = 4'd3,
        S4       = 4'd4,
        S5       = 4'd5,
        S6       = 4'd6,
        S7       = 4'd7,
        S_HALTED = 4'd8
    } state_e;

    typedef struct packed {
        logic halt;
        logic datactl_ena;
        logic load_ir;
        logic wr;
        logic rd;
        logic load_pc;
        logic load_acc;
        logic inc_pc;
    } ctl_t;

    state_e state_q, state_d;
    logic   en_q, en_d;
    ctl_t   ctl_q, ctl_d;

    logic alu_op;
    assign alu_op = (bus.opcode == OP_ADD)  || (bus.opcode == OP_ANDD) ||
                    (bus.opcode == OP_XORR) || (bus.opcode == OP_LDA);

    // Enable flag: set by the first sampled fetch strobe, sticky until reset.
    always_comb begin
        en_d = en_q | bus.fetch;
    end

    // State, enable and registered control word; reset wins over everything.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q <= S0;
            en_q    <= 1'b0;
            ctl_q   <= '0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            ctl_q   <= ctl_d;
        end
    end

    // Next-state: advance one step per clock while enabled.
    always_comb begin
        // NOTE: default first so no path through the case leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            S0: if (en_q) state_d = S1;
            S1: if (en_q) state_d = S2;
            S2: if (en_q) state_d = S3;
            S3: begin
                if (en_q) begin
`ifdef MACHINE_CTL_HALT_LATCH_EN
                    state_d = (bus.opcode == OP_HLT) ? S_HALTED : S4;
`else
                    state_d = S4;
`endif
                end
            end
            S4: if (en_q) state_d = S5;
            S5: if (en_q) state_d = S6;
            S6: if (en_q) state_d = S7;
            S7: if (en_q) state_d = S0;
`ifdef MACHINE_CTL_HALT_LATCH_EN
            S_HALTED: state_d = S_HALTED;
`endif
            default: state_d = S0;
        endcase
    end

    // Control word for the step being processed on this edge.
    always_comb begin
        ctl_d = '0;
        if (en_q) begin
            case (state_q)
                S0, S1: begin
                    ctl_d.rd      = 1'b1;
                    ctl_d.load_ir = 1'b1;
                    ctl_d.inc_pc  = 1'b1;
                end
                S3: begin
                    if (bus.opcode == OP_HLT) ctl_d.halt   = 1'b1;
                    else                      ctl_d.inc_pc = 1'b1;
                end
                S4: begin
                    if (bus.opcode == OP_JMP)      ctl_d.load_pc     = 1'b1;
                    else if (alu_op)               ctl_d.rd          = 1'b1;
                    else if (bus.opcode == OP_STO) ctl_d.datactl_ena = 1'b1;
                end
                S5: begin
                    if (alu_op) begin
                        ctl_d.rd       = 1'b1;
                        ctl_d.load_acc = 1'b1;
                    end else if (bus.opcode == OP_SKZ) begin
                        ctl_d.inc_pc = bus.zero;
                    end else if (bus.opcode == OP_JMP) begin
                        ctl_d.load_pc = 1'b1;
                        ctl_d.inc_pc  = 1'b1;
                    end else if (bus.opcode == OP_STO) begin
                        ctl_d.wr          = 1'b1;
                        ctl_d.datactl_ena = 1'b1;
                    end
                end
                S6: begin
                    if (bus.opcode == OP_STO) ctl_d.datactl_ena = 1'b1;
                    else if (alu_op)          ctl_d.rd          = 1'b1;
                end
                S7: begin
                    if (bus.opcode == OP_SKZ) ctl_d.inc_pc = bus.zero;
                end
`ifdef MACHINE_CTL_HALT_LATCH_EN
                S_HALTED: ctl_d.halt = 1'b1;
`endif
                default: ctl_d = '0;
            endcase
        end
    end

    assign bus.inc_pc      = ctl_q.inc_pc;
    assign bus.load_acc    = ctl_q.load_acc;
    assign bus.load_pc     = ctl_q.load_pc;
    assign bus.rd          = ctl_q.rd;
    assign bus.wr          = ctl_q.wr;
    assign bus.load_ir     = ctl_q.load_ir;
    assign bus.datactl_ena = ctl_q.datactl_ena;
    assign bus.halt        = ctl_q.halt;

endmodule
